// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one sync_fifo write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_active,
    output logic [GW-1:0]                 grant_id
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state;
    logic [3:0]    beat_cnt;
    logic [GW-1:0] last_ptr;
    logic          sel_found;
    logic [GW-1:0] sel_idx;
    logic          in_burst;
    logic          last_beat;

    // Scan starts just past the previous winner so every requester gets a turn.
    always_comb begin
        int scan;
        sel_found = 1'b0;
        sel_idx   = '0;
        scan      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = (int'(last_ptr) + k) % NUM_REQ;
            if (!sel_found && req_valid[scan]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(scan);
            end
        end
    end

    // Reset masks the handshake immediately, before the state registers clear.
    always_comb begin
        in_burst     = (state == BURST) && !rst;
        fifo_wr      = in_burst && req_valid[grant_id] && !fifo_full;
        req_ready    = (in_burst && !fifo_full) ?
                       ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
        fifo_data_in = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        last_beat    = (beat_cnt + 4'd1) == 4'(MAX_BURST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant_active <= 1'b0;
            grant_id     <= '0;
            beat_cnt     <= '0;
            last_ptr     <= GW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state        <= BURST;
                        grant_active <= 1'b1;
                        grant_id     <= sel_idx;
                        last_ptr     <= sel_idx;
                        beat_cnt     <= '0;
                    end
                end
                BURST: begin
                    if (!req_valid[grant_id]) begin
                        state        <= IDLE;
                        grant_active <= 1'b0;
                        beat_cnt     <= '0;
                    end else if (fifo_wr) begin
                        if (last_beat) begin
                            state        <= IDLE;
                            grant_active <= 1'b0;
                            beat_cnt     <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a depth-16 FIFO model
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data_in;
    logic        grant_active;
    logic [1:0]  grant_id;

    logic        full_drv;
    logic        use_model;
    logic        fifo_rd;

    logic [7:0]  mem [16];
    logic [3:0]  wptr;
    logic [3:0]  rptr;
    logic [4:0]  cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_data_in(fifo_data_in),
        .grant_active(grant_active),
        .grant_id    (grant_id)
    );

    assign fifo_full = use_model ? (cnt == 5'd16) : full_drv;

    always @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wptr] <= fifo_data_in;
                wptr      <= wptr + 4'd1;
            end
            if (fifo_rd && cnt != 5'd0)
                rptr <= rptr + 4'd1;
            cnt <= cnt + 5'(fifo_wr) - 5'(fifo_rd && cnt != 5'd0);
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        full;
        logic        wr;
        logic [7:0]  dat;
        logic [3:0]  rdy;
        logic        act;
        logic [1:0]  gid;
    } vec_t;

    vec_t vecs [22];
    logic [7:0] readback [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nwr;
        int  word;
        int  cycles;
        logic acc;

        // reset, single requester, stall and grant hand-off, cycle by cycle
        vecs[0]  = '{1'b1, 4'b1111, 32'hD3C2B1A0, 1'b0, 1'b0, 8'hA0, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'b1111, 32'hD3C2B1A0, 1'b0, 1'b0, 8'hA0, 4'b0000, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'b0001, 32'hD3C2B1A0, 1'b0, 1'b1, 8'hA0, 4'b0001, 1'b1, 2'd0};
        vecs[3]  = '{1'b0, 4'b0000, 32'hD3C2B1A0, 1'b0, 1'b0, 8'hA0, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{1'b0, 4'b0010, 32'h00001100, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 4'b0010, 32'h00001100, 1'b0, 1'b1, 8'h11, 4'b0010, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 4'b0010, 32'h00002200, 1'b0, 1'b1, 8'h22, 4'b0010, 1'b1, 2'd1};
        vecs[7]  = '{1'b0, 4'b0010, 32'h00003300, 1'b0, 1'b1, 8'h33, 4'b0010, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 4'b0000, 32'h00003300, 1'b0, 1'b0, 8'h33, 4'b0010, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 4'b0000, 32'h00003300, 1'b0, 1'b0, 8'h33, 4'b0000, 1'b0, 2'd1};
        vecs[10] = '{1'b0, 4'b1100, 32'hD0C10000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        vecs[11] = '{1'b0, 4'b1100, 32'hD0C10000, 1'b0, 1'b1, 8'hC1, 4'b0100, 1'b1, 2'd2};
        vecs[12] = '{1'b0, 4'b1100, 32'hD0C20000, 1'b0, 1'b1, 8'hC2, 4'b0100, 1'b1, 2'd2};
        vecs[13] = '{1'b0, 4'b1100, 32'hD0C30000, 1'b1, 1'b0, 8'hC3, 4'b0000, 1'b1, 2'd2};
        vecs[14] = '{1'b0, 4'b1100, 32'hD0C30000, 1'b1, 1'b0, 8'hC3, 4'b0000, 1'b1, 2'd2};
        vecs[15] = '{1'b0, 4'b1100, 32'hD0C30000, 1'b1, 1'b0, 8'hC3, 4'b0000, 1'b1, 2'd2};
        vecs[16] = '{1'b0, 4'b1100, 32'hD0C30000, 1'b0, 1'b1, 8'hC3, 4'b0100, 1'b1, 2'd2};
        vecs[17] = '{1'b0, 4'b1100, 32'hD0C40000, 1'b0, 1'b1, 8'hC4, 4'b0100, 1'b1, 2'd2};
        vecs[18] = '{1'b0, 4'b1100, 32'hD0C50000, 1'b0, 1'b0, 8'hC5, 4'b0000, 1'b0, 2'd2};
        vecs[19] = '{1'b0, 4'b1000, 32'hD0C50000, 1'b0, 1'b1, 8'hD0, 4'b1000, 1'b1, 2'd3};
        vecs[20] = '{1'b0, 4'b0000, 32'hD0C50000, 1'b0, 1'b0, 8'hD0, 4'b1000, 1'b1, 2'd3};
        vecs[21] = '{1'b0, 4'b0000, 32'hD0C50000, 1'b0, 1'b0, 8'hD0, 4'b0000, 1'b0, 2'd3};

        readback = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD0};

        use_model = 1'b0;
        fifo_rd   = 1'b0;

        for (int i = 0; i < 22; i++) begin
            rst       = vecs[i].rst;
            req_valid = vecs[i].v;
            req_data  = vecs[i].d;
            full_drv  = vecs[i].full;
            @(negedge clk);
            check($sformatf("vec%0d_wr", i),    32'(fifo_wr),      32'(vecs[i].wr));
            check($sformatf("vec%0d_data", i),  32'(fifo_data_in), 32'(vecs[i].dat));
            check($sformatf("vec%0d_ready", i), 32'(req_ready),    32'(vecs[i].rdy));
            check($sformatf("vec%0d_active", i), 32'(grant_active), 32'(vecs[i].act));
            check($sformatf("vec%0d_gid", i),   32'(grant_id),     32'(vecs[i].gid));
            next_cycle();
        end

        // FIFO contents written during the table, in order
        fifo_rd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("readback%0d", i), 32'(mem[rptr]), 32'(readback[i]));
            next_cycle();
        end
        fifo_rd = 1'b0;

        // all four requesters continuously valid
        rst       = 1'b1;
        req_valid = 4'b0000;
        full_drv  = 1'b0;
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h33221100;
        nwr       = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_wr) begin
                check($sformatf("rr_write%0d_gid", nwr), 32'(grant_id), 32'(nwr / 4));
                check($sformatf("rr_write%0d_data", nwr), 32'(fifo_data_in), 32'((nwr / 4) * 8'h11));
                nwr++;
            end
            next_cycle();
        end
        check("rr_writes_in_20_cycles", 32'(nwr), 32'd16);
        @(negedge clk);
        check("rr_gap_wr", 32'(fifo_wr), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rr_wrap_wr", 32'(fifo_wr), 32'd1);
        check("rr_wrap_gid", 32'(grant_id), 32'd0);
        next_cycle();

        // requester 0 alone overfills a depth-16 FIFO
        rst       = 1'b1;
        req_valid = 4'b0000;
        use_model = 1'b1;
        next_cycle();
        rst       = 1'b0;
        word      = 1;
        req_valid = 4'b0001;
        req_data  = 32'(word);
        cycles    = 0;
        while (word <= 16 && cycles < 40) begin
            @(negedge clk);
            acc = req_ready[0];
            next_cycle();
            cycles++;
            if (acc)
                word++;
            req_data = 32'(word);
        end
        check("full_accepted_words", 32'(word - 1), 32'd16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("full_hold%0d_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("full_hold%0d_wr", i), 32'(fifo_wr), 32'd0);
            next_cycle();
        end
        fifo_rd = 1'b1;
        @(negedge clk);
        check("full_read_cycle_wr", 32'(fifo_wr), 32'd0);
        check("full_first_read", 32'(mem[rptr]), 32'd1);
        next_cycle();
        fifo_rd = 1'b0;
        @(negedge clk);
        check("full_released_wr", 32'(fifo_wr), 32'd1);
        check("full_released_data", 32'(fifo_data_in), 32'h11);
        check("full_released_ready", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = 4'b0000;
        fifo_rd   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("full_drain%0d", i), 32'(mem[rptr]), 32'(i + 2));
            next_cycle();
        end
        fifo_rd = 1'b0;

        // reset in the middle of a burst from requester 3
        rst       = 1'b1;
        use_model = 1'b0;
        full_drv  = 1'b0;
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b1000;
        req_data  = 32'h3C001C00;
        next_cycle();
        @(negedge clk);
        check("midrst_beat1_gid", 32'(grant_id), 32'd3);
        check("midrst_beat1_wr", 32'(fifo_wr), 32'd1);
        next_cycle();
        @(negedge clk);
        check("midrst_beat2_wr", 32'(fifo_wr), 32'd1);
        next_cycle();
        rst       = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        check("midrst_during_wr", 32'(fifo_wr), 32'd0);
        check("midrst_during_ready", 32'(req_ready), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_after_active", 32'(grant_active), 32'd0);
        check("midrst_after_gid", 32'(grant_id), 32'd0);
        check("midrst_after_wr", 32'(fifo_wr), 32'd0);
        next_cycle();
        @(negedge clk);
        check("midrst_regrant_gid", 32'(grant_id), 32'd1);
        check("midrst_regrant_active", 32'(grant_active), 32'd1);
        check("midrst_regrant_wr", 32'(fifo_wr), 32'd1);
        check("midrst_regrant_data", 32'(fifo_data_in), 32'h1C);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
